// File: rtl/avmm_rr_arbiter2_if.sv
// rtl/avmm_rr_arbiter2_if.sv - Avalon-MM master link with waitrequest/readdatavalid handshake
interface avmm_rr_arbiter2_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] address;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              read;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, write, writedata, read,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, write, writedata, read,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/avmm_rr_arbiter2.sv
// rtl/avmm_rr_arbiter2.sv - two-master round-robin arbiter onto one fixed-latency Avalon-MM slave
module avmm_rr_arbiter2 #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_in,
   avmm_rr_arbiter2_if.slave m0,
   avmm_rr_arbiter2_if.slave m1,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   output logic              s_read,
   input  logic [DATA_W-1:0] s_readdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RD_RESP} state_t;

   state_t            state;
   logic              gnt;      // 0 = m0, 1 = m1
   logic              gnt_wr;
   logic              ptr;      // master favoured on the next tie
   logic [1:0]        cnt;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;

   logic req0, req1, gnt_nxt, gnt_live, issue;

   assign req0     = m0.read | m0.write;
   assign req1     = m1.read | m1.write;
   assign gnt_nxt  = (req0 & req1) ? ptr : req1;
   assign gnt_live = gnt ? req1 : req0;
   // A master that dropped its request before issue gets no strobe and no accept.
   assign issue    = (state == ISSUE) && gnt_live;

   always_comb begin
      s_address   = '0;
      s_write     = 1'b0;
      s_read      = 1'b0;
      s_writedata = '0;
      if (issue) begin
         s_address = gnt ? m1.address : m0.address;
         s_write   = gnt_wr;
         s_read    = !gnt_wr;
         if (gnt_wr)
            s_writedata = gnt ? m1.writedata : m0.writedata;
      end
   end

   assign m0.waitrequest   = !(issue && !gnt);
   assign m1.waitrequest   = !(issue && gnt);
   assign m0.readdatavalid = (state == RD_RESP) && !gnt;
   assign m1.readdatavalid = (state == RD_RESP) && gnt;
   assign m0.readdata      = rdata0;
   assign m1.readdata      = rdata1;

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state  <= IDLE;
         gnt    <= 1'b0;
         gnt_wr <= 1'b0;
         ptr    <= 1'b0;
         cnt    <= '0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  gnt    <= gnt_nxt;
                  gnt_wr <= gnt_nxt ? m1.write : m0.write;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (gnt_live) begin
                  ptr   <= ~gnt;
                  cnt   <= 2'(RD_LAT - 1);
                  state <= gnt_wr ? IDLE : RD_WAIT;
               end else begin
                  state <= IDLE;
               end
            end
            RD_WAIT: begin
               if (cnt == 2'd0) begin
                  if (gnt)
                     rdata1 <= s_readdata;
                  else
                     rdata0 <= s_readdata;
                  state <= RD_RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RD_RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_avmm_rr_arbiter2.sv
// tb/tb_avmm_rr_arbiter2.sv - directed-vector bench for avmm_rr_arbiter2 (RD_LAT 1 and 3 instances)
module tb_avmm_rr_arbiter2;
   logic clk;
   logic rst_in;

   avmm_rr_arbiter2_if #(.ADDR_W(8), .DATA_W(32)) a_m0();
   avmm_rr_arbiter2_if #(.ADDR_W(8), .DATA_W(32)) a_m1();
   avmm_rr_arbiter2_if #(.ADDR_W(8), .DATA_W(32)) b_m0();
   avmm_rr_arbiter2_if #(.ADDR_W(8), .DATA_W(32)) b_m1();

   logic [7:0]  s_address_a, s_address_b;
   logic        s_write_a, s_write_b, s_read_a, s_read_b;
   logic [31:0] s_writedata_a, s_writedata_b, s_readdata_a, s_readdata_b;

   avmm_rr_arbiter2 #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dut (
      .clk(clk), .rst_in(rst_in), .m0(a_m0), .m1(a_m1),
      .s_address(s_address_a), .s_write(s_write_a), .s_writedata(s_writedata_a),
      .s_read(s_read_a), .s_readdata(s_readdata_a)
   );

   avmm_rr_arbiter2 #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) dut3 (
      .clk(clk), .rst_in(rst_in), .m0(b_m0), .m1(b_m1),
      .s_address(s_address_b), .s_write(s_write_b), .s_writedata(s_writedata_b),
      .s_read(s_read_b), .s_readdata(s_readdata_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave models: read data depends on address, returned exactly RD_LAT cycles after s_read.
   function automatic logic [31:0] rd_val(input logic [7:0] a);
      return 32'h12345674 + {24'h0, a};
   endfunction

   logic [31:0] pipe_a;
   logic [31:0] pipe_b [3];
   always @(posedge clk) begin
      pipe_a    <= s_read_a ? rd_val(s_address_a) : 32'h0;
      pipe_b[0] <= s_read_b ? rd_val(s_address_b) : 32'h0;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign s_readdata_a = pipe_a;
   assign s_readdata_b = pipe_b[2];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [15:0] w_sw, w_sr, w_rdv0, w_rdv1, w_wt0, w_wt1;
   logic [31:0] w_addr, w_wd;
   bit          w_seen;

   // Runs n cycles on one instance, recording per-cycle strobes; a master drops its request once accepted.
   task automatic run(input bit b, input int n);
      logic sw, sr, r0, r1, t0, t1;
      logic [7:0]  ad;
      logic [31:0] wd;
      w_sw = '0; w_sr = '0; w_rdv0 = '0; w_rdv1 = '0; w_wt0 = '0; w_wt1 = '0;
      w_addr = '0; w_wd = '0; w_seen = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         sw = b ? s_write_b : s_write_a;
         sr = b ? s_read_b : s_read_a;
         ad = b ? s_address_b : s_address_a;
         wd = b ? s_writedata_b : s_writedata_a;
         r0 = b ? b_m0.readdatavalid : a_m0.readdatavalid;
         r1 = b ? b_m1.readdatavalid : a_m1.readdatavalid;
         t0 = b ? b_m0.waitrequest : a_m0.waitrequest;
         t1 = b ? b_m1.waitrequest : a_m1.waitrequest;
         w_sw[c] = sw; w_sr[c] = sr; w_rdv0[c] = r0; w_rdv1[c] = r1; w_wt0[c] = t0; w_wt1[c] = t1;
         if ((sw | sr) && !w_seen) begin
            w_seen = 1'b1; w_addr = {24'h0, ad}; w_wd = wd;
         end
         @(posedge clk); #1;
         if (!t0) begin
            if (b) begin b_m0.write = 1'b0; b_m0.read = 1'b0; end
            else   begin a_m0.write = 1'b0; a_m0.read = 1'b0; end
         end
         if (!t1) begin
            if (b) begin b_m1.write = 1'b0; b_m1.read = 1'b0; end
            else   begin a_m1.write = 1'b0; a_m1.read = 1'b0; end
         end
      end
   endtask

   task automatic idle_masters();
      a_m0.write = 0; a_m0.read = 0; a_m0.address = 0; a_m0.writedata = 0;
      a_m1.write = 0; a_m1.read = 0; a_m1.address = 0; a_m1.writedata = 0;
      b_m0.write = 0; b_m0.read = 0; b_m0.address = 0; b_m0.writedata = 0;
      b_m1.write = 0; b_m1.read = 0; b_m1.address = 0; b_m1.writedata = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] logd [8];
   int          logc [8];
   int          nlog, k0, k1;
   logic        acc0, acc1;

   initial begin
      // Reset with garbage on the master inputs.
      rst_in = 1'b0;
      idle_masters();
      repeat (3) begin
         @(posedge clk); #1;
         a_m0.write = 1'($urandom); a_m0.read = 1'($urandom); a_m0.address = 8'($urandom);
         a_m1.write = 1'($urandom); a_m1.read = 1'($urandom); a_m1.writedata = $urandom;
         b_m0.read  = 1'($urandom); b_m1.write = 1'($urandom);
      end
      @(negedge clk);
      chk("rst_wait0", {31'h0, a_m0.waitrequest}, 32'h1);
      chk("rst_wait1", {31'h0, a_m1.waitrequest}, 32'h1);
      chk("rst_rdv", {30'h0, a_m0.readdatavalid, a_m1.readdatavalid}, 32'h0);
      chk("rst_sstrobe", {30'h0, s_write_a, s_read_a}, 32'h0);
      chk("rst_saddr", {24'h0, s_address_a}, 32'h0);
      chk("rst_swdata", s_writedata_a, 32'h0);
      chk("rst_rdata0", a_m0.readdata, 32'h0);
      chk("rst_b_wait", {30'h0, b_m0.waitrequest, b_m1.waitrequest}, 32'h3);
      @(posedge clk); #1;
      idle_masters();
      rst_in = 1'b1;

      // Continuous contention of writes right after reset: m0 first, then strict alternation.
      nlog = 0; k0 = 0; k1 = 0;
      for (int c = 0; c < 24; c++) begin
         a_m0.write = (k0 < 4); a_m0.address = 8'h20 + 8'(k0); a_m0.writedata = 32'hA0 + 32'(k0);
         a_m1.write = (k1 < 4); a_m1.address = 8'h30 + 8'(k1); a_m1.writedata = 32'hB0 + 32'(k1);
         @(negedge clk);
         if (s_write_a && nlog < 8) begin
            logd[nlog] = s_writedata_a; logc[nlog] = c; nlog++;
         end
         acc0 = !a_m0.waitrequest;
         acc1 = !a_m1.waitrequest;
         @(posedge clk); #1;
         if (acc0) k0++;
         if (acc1) k1++;
      end
      idle_masters();
      chk("cont_count", 32'(nlog), 32'd8);
      chk("cont_done", {16'(k0), 16'(k1)}, {16'd4, 16'd4});
      for (int i = 0; i < nlog; i++) begin
         chk($sformatf("cont_data%0d", i), logd[i],
             (i % 2 == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2));
         if (i > 0) chk($sformatf("cont_gap%0d", i), 32'(logc[i] - logc[i-1]), 32'd2);
      end

      // Single m0 write.
      a_m0.write = 1; a_m0.address = 8'h10; a_m0.writedata = 32'hDEADBEEF;
      run(0, 4);
      chk("wr_swrite", 32'(w_sw), 32'b0010);
      chk("wr_wait0", 32'(w_wt0), 32'b1101);
      chk("wr_wait1", 32'(w_wt1), 32'b1111);
      chk("wr_addr", w_addr, 32'h10);
      chk("wr_data", w_wd, 32'hDEADBEEF);

      // Single m1 read, RD_LAT=1.
      a_m1.read = 1; a_m1.address = 8'h04;
      run(0, 6);
      chk("rd_sread", 32'(w_sr), 32'b000010);
      chk("rd_addr", w_addr, 32'h04);
      chk("rd_wait1", 32'(w_wt1), 32'b111101);
      chk("rd_rdv1", 32'(w_rdv1), 32'b001000);
      chk("rd_rdv0", 32'(w_rdv0), 32'h0);
      chk("rd_data1", a_m1.readdata, 32'h12345678);

      // Move the pointer to m1, then m0 read and m1 write together.
      a_m0.write = 1; a_m0.address = 8'h01; a_m0.writedata = 32'h1;
      run(0, 3);
      chk("pre_swrite", 32'(w_sw), 32'b010);
      a_m0.read = 1; a_m0.address = 8'h08;
      a_m1.write = 1; a_m1.address = 8'h40; a_m1.writedata = 32'h55AA55AA;
      run(0, 8);
      chk("mix_swrite", 32'(w_sw), 32'b00000010);
      chk("mix_wdata", w_wd, 32'h55AA55AA);
      chk("mix_sread", 32'(w_sr), 32'b00001000);
      chk("mix_wait0", 32'(w_wt0), 32'b11110111);
      chk("mix_wait1", 32'(w_wt1), 32'b11111101);
      chk("mix_rdv0", 32'(w_rdv0), 32'b00100000);
      chk("mix_data0", a_m0.readdata, 32'h1234567C);

      // RD_LAT=3: normal read latency.
      b_m0.read = 1; b_m0.address = 8'h0C;
      run(1, 8);
      chk("l3_sread", 32'(w_sr), 32'b00000010);
      chk("l3_rdv0", 32'(w_rdv0), 32'b00100000);
      chk("l3_data0", b_m0.readdata, 32'h12345680);

      // RD_LAT=3: reset pulsed while the read waits on the slave.
      b_m0.read = 1; b_m0.address = 8'h14;
      run(1, 3);
      rst_in = 1'b0;
      @(negedge clk);
      chk("mid_wait", {30'h0, b_m0.waitrequest, b_m1.waitrequest}, 32'h3);
      chk("mid_rdv", {30'h0, b_m0.readdatavalid, b_m1.readdatavalid}, 32'h0);
      chk("mid_rdata0", b_m0.readdata, 32'h0);
      @(posedge clk); #1;
      rst_in = 1'b1;
      run(1, 8);
      chk("mid_no_rdv", {16'(w_rdv0), 16'(w_rdv1)}, 32'h0);
      chk("mid_quiet", {16'(w_sw), 16'(w_sr)}, 32'h0);

      // Pointer back at m0 after reset; then a normal read again.
      b_m0.write = 1; b_m0.address = 8'h50; b_m0.writedata = 32'h5;
      b_m1.write = 1; b_m1.address = 8'h60; b_m1.writedata = 32'h6;
      run(1, 6);
      chk("post_swrite", 32'(w_sw), 32'b001010);
      chk("post_first", w_addr, 32'h50);
      b_m0.read = 1; b_m0.address = 8'h0C;
      run(1, 8);
      chk("post_rdv0", 32'(w_rdv0), 32'b00100000);
      chk("post_data0", b_m0.readdata, 32'h12345680);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
